// File: rtl/dct_rx_ctrl.sv
// Purpose: frame sequencer between UART receiver and DCT engine (sync hunt, block load, checksum, start/hold-off).
// Latency: every output is registered; a byte strobe at cycle T shows its effect (write, start, error) at T+1.
// Backpressure: none toward the receiver; bytes arriving while the engine is busy are dropped with an overrun pulse.
module dct_rx_ctrl #(
    parameter int         ADDR_W         = 6,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 187500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              dct_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              dct_start,
    output logic              busy,
    output logic              err_checksum,
    output logic              err_timeout,
    output logic              overrun,
    output logic [7:0]        frame_count
);

    // Inter-byte timer is a fixed 24-bit counter; the limit is compared one
    // count early so the abandon decision lands on the cycle the count would
    // reach TIMEOUT_CYCLES.
    localparam int               TMR_W    = 24;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic [TMR_W-1:0]  timer;

    // Per-cycle decisions taken by the sequencer.
    logic in_frame;     // LOAD or CHECK: the timer is running
    logic last_addr;    // current address is the final slot of the block
    logic timer_hit;    // timer is one count short of the limit
    logic sync_hit;     // a sync byte seen while hunting
    logic load_byte;    // sample byte written into the buffer
    logic chk_ok;       // checksum byte matches the running sum
    logic chk_bad;      // checksum byte differs from the running sum
    logic tmo;          // frame abandoned for inactivity
    logic drop;         // byte discarded because the engine is busy

    assign in_frame  = (state == ST_LOAD) || (state == ST_CHECK);
    assign last_addr = (addr == {ADDR_W{1'b1}});
    assign timer_hit = (timer == TMR_LAST);

    // Next-state and event decode; an arriving byte always takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        sync_hit  = 1'b0;
        load_byte = 1'b0;
        chk_ok    = 1'b0;
        chk_bad   = 1'b0;
        tmo       = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_HUNT: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    sync_hit  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (rx_valid) begin
                    load_byte = 1'b1;
                    if (last_addr) begin
                        state_nxt = ST_CHECK;
                    end
                end else if (timer_hit) begin
                    tmo       = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == sum) begin
                        chk_ok    = 1'b1;
                        state_nxt = ST_BUSY;
                    end else begin
                        chk_bad   = 1'b1;
                        state_nxt = ST_HUNT;
                    end
                end else if (timer_hit) begin
                    tmo       = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            default: begin
                // Engine running: nothing is accepted, not even a sync byte.
                drop = rx_valid;
                if (dct_done) begin
                    state_nxt = ST_HUNT;
                end
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Write address and running checksum: cleared on sync, advanced per sample byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            sum  <= '0;
        end else if (sync_hit) begin
            addr <= '0;
            sum  <= '0;
        end else if (load_byte) begin
            addr <= addr + 1'b1;
            sum  <= sum + rx_byte;
        end
    end

    // Inter-byte idle timer: runs only inside a frame, restarts on every byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!in_frame || rx_valid || tmo) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Buffer write port: one-cycle strobe with the address and data of the sample byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= load_byte;
            if (load_byte) begin
                wr_addr <= addr;
                wr_data <= rx_byte;
            end
        end
    end

    // One-cycle status pulses for start, checksum error, timeout and overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_start    <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            dct_start    <= chk_ok;
            err_checksum <= chk_bad;
            err_timeout  <= tmo;
            overrun      <= drop;
        end
    end

    // Busy flag mirrors the engine-running state; frame counter counts verified frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            busy <= (state_nxt == ST_BUSY);
            if (chk_ok) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule
